// File: rtl/soc_pkg.sv
// Shared SoC definitions: test-host register map,
// status bit layout and test-host state encoding.
package soc_pkg;

  localparam logic [1:0] REG_TOHOST = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;
  localparam logic [1:0] REG_WDOG   = 2'd3;

  localparam int ST_DONE    = 0;
  localparam int ST_PASS    = 1;
  localparam int ST_FAIL    = 2;
  localparam int ST_TIMEOUT = 3;

  typedef enum logic [1:0] {
    TH_RUN,
    TH_PASS,
    TH_FAIL,
    TH_TIMEOUT
  } th_state_e;

  function automatic logic [31:0] status_word(
    input logic dn,
    input logic ps,
    input logic fl,
    input logic to
  );
    logic [31:0] w;
    w = '0;
    w[ST_DONE]    = dn;
    w[ST_PASS]    = ps;
    w[ST_FAIL]    = fl;
    w[ST_TIMEOUT] = to;
    return w;
  endfunction

endpackage

// File: rtl/test_host.sv
// Test host: tohost pass/fail mailbox, cycle counter
// and watchdog on a valid/ready request/response bus.
module test_host
  import soc_pkg::*;
#(
  parameter logic [31:0] WDOG_RESET = 32'd10000,
  parameter int          ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [30:0]       fail_code
);

  th_state_e   state_q, state_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] wdog_q, wdog_d;
  logic [31:0] tohost_q, tohost_d;
  logic [30:0] code_q, code_d;
  logic        rv_q, rv_d;
  logic [31:0] rdata_q, rdata_d;

  logic       acc, run, full, th_wr;
  logic       pass_wr, fail_wr, to_hit;
  logic [1:0] sel;
  logic       unused_addr;

  assign unused_addr = ^{req_addr[ADDR_W-1:4], req_addr[1:0]};

  // ready stays high in reset so the core never sees a stall there
  assign req_ready = !rst || !rv_q || resp_ready;

  assign sel     = req_addr[3:2];
  assign acc     = req_valid && req_ready;
  assign run     = state_q == TH_RUN;
  assign full    = req_wstrb == 4'hF;
  assign th_wr   = acc && req_we && sel == REG_TOHOST;
  assign pass_wr = th_wr && full && run && req_wdata == 32'd1;
  assign fail_wr = th_wr && full && run && req_wdata[0]
                && req_wdata[31:1] != '0;
  assign to_hit  = run && wdog_q != '0 && cycle_q == wdog_q;

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    wdog_d   = wdog_q;
    tohost_d = tohost_q;
    code_d   = code_q;
    rv_d     = rv_q;
    rdata_d  = rdata_q;

    if (pass_wr) begin
      state_d = TH_PASS;
    end else if (fail_wr) begin
      state_d = TH_FAIL;
      code_d  = req_wdata[31:1];
    end else if (to_hit) begin
      state_d = TH_TIMEOUT;
    end

    if (run && cycle_q != 32'hFFFF_FFFF)
      cycle_d = cycle_q + 32'd1;

    if (th_wr && full && run)
      tohost_d = req_wdata;

    if (acc && req_we && sel == REG_WDOG) begin
      for (int i = 0; i < 4; i++)
        if (req_wstrb[i])
          wdog_d[8*i +: 8] = req_wdata[8*i +: 8];
    end

    if (rv_q && resp_ready)
      rv_d = 1'b0;

    if (acc) begin
      rv_d = 1'b1;
      if (req_we) begin
        rdata_d = '0;
      end else begin
        case (sel)
          REG_TOHOST: rdata_d = tohost_q;
          REG_STATUS: rdata_d = status_word(done, pass, fail, timeout);
          REG_CYCLE:  rdata_d = cycle_q;
          default:    rdata_d = wdog_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= TH_RUN;
      cycle_q  <= '0;
      wdog_q   <= WDOG_RESET;
      tohost_q <= '0;
      code_q   <= '0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      wdog_q   <= wdog_d;
      tohost_q <= tohost_d;
      code_q   <= code_d;
      rv_q     <= rv_d;
      rdata_q  <= rdata_d;
    end
  end

  assign resp_valid = rv_q;
  assign resp_rdata = rdata_q;
  assign pass       = state_q == TH_PASS;
  assign fail       = state_q == TH_FAIL;
  assign timeout    = state_q == TH_TIMEOUT;
  assign done       = state_q != TH_RUN;
  assign fail_code  = code_q;

endmodule

// File: doc/test_host.md
TEST_HOST -- requirements
Module: test_host

Interface
REQ-001 SHALL have parameter WDOG_RESET, default 32'd10000, reset value of watchdog limit in cycles.
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (asserted when 0, sampled on rising clk).
REQ-005 req_valid  input  1  core request present.
REQ-006 req_ready  output  1  block accepts request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  byte address; only bits [3:2] decoded.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_wstrb  input  4  byte enables.
REQ-011 resp_valid  output  1  response (read data or write ack) present.
REQ-012 resp_ready  input  1  core takes response.
REQ-013 resp_rdata  output  32  read data; 0 for writes.
REQ-014 done  output  1  test finished (pass, fail or timeout).
REQ-015 pass  output  1  finished by pass write.
REQ-016 fail  output  1  finished by fail write.
REQ-017 timeout  output  1  finished by watchdog.
REQ-018 fail_code  output  31  code from fail write.

Function
REQ-019 Register map by req_addr[3:2]: 0 TOHOST, 1 STATUS (RO), 2 CYCLE (RO), 3 WDOG (RW).
REQ-020 Handshake: request accepted when req_valid && req_ready; resp_valid asserts the next cycle, held with stable resp_rdata until resp_valid && resp_ready.
REQ-021 req_ready = !resp_valid || resp_ready; back-to-back accepts give one response per cycle, no bubbles.
REQ-022 State machine RUN -> {PASS, FAIL, TIMEOUT}; PASS/FAIL/TIMEOUT are terminal until reset.
REQ-023 TOHOST write, wstrb==4'hF only, in RUN: value 1 -> PASS; odd value >1 -> FAIL, fail_code = wdata[31:1]; 0 or even value -> no state change.
REQ-024 TOHOST write with partial wstrb, or in a terminal state, changes no state but is still acknowledged.
REQ-025 TOHOST read returns last full-word value written (0 after reset).
REQ-026 STATUS read = {28'b0, timeout, fail, pass, done}.
REQ-027 CYCLE increments by 1 each cycle in RUN, freezes in terminal states, saturates at 32'hFFFF_FFFF.
REQ-028 WDOG write updates bytes selected by wstrb; read returns current value; value 0 disables watchdog.
REQ-029 In RUN, WDOG != 0 and CYCLE == WDOG -> TIMEOUT next cycle.
REQ-030 TOHOST pass/fail write accepted in the same cycle as the timeout condition takes priority; TIMEOUT not entered.
REQ-031 done = pass | fail | timeout; at most one of pass/fail/timeout is ever 1.
REQ-032 Writes to STATUS or CYCLE are acknowledged and ignored.

Reset
REQ-033 On rst==0 at rising clk: state RUN, CYCLE 0, WDOG = WDOG_RESET, TOHOST 0, fail_code 0, resp_valid 0, resp_rdata 0, done/pass/fail/timeout 0.
REQ-034 Reset during an outstanding response SHALL drop it; no response issued for that request after reset.
REQ-035 req_ready SHALL be 1 during and immediately after reset.

Structure
REQ-036 Register offsets, STATUS bit positions and state encoding SHALL live in a shared package soc_pkg.
REQ-037 Single module, no sub-modules; instantiated in soc on the data bus beside ram.

Verification
REQ-038 Write TOHOST=32'h1 at cycle 20 -> next cycle pass=1, done=1; STATUS reads 32'h3; CYCLE frozen at 21.
REQ-039 Write TOHOST=32'h7 -> fail=1, fail_code=3, STATUS reads 32'h5; later write 32'h1 acked, pass stays 0.
REQ-040 WDOG=5 written at cycle 1, no TOHOST -> timeout=1 once CYCLE reaches 5; WDOG=0 -> no timeout over 10000 cycles.
REQ-041 TOHOST=32'h1 accepted in the timeout cycle -> pass=1, timeout=0.
REQ-042 Three back-to-back reads with resp_ready low 2 cycles -> req_ready 0 while stalled, three responses in order, rdata stable while stalled.
REQ-043 Partial write TOHOST (wstrb=4'h1, data 1) -> acked, state RUN; reset asserted mid-response -> resp_valid 0 after reset, all outputs at reset values.
